// File: rtl/core_pkg.sv
// Shared RV32I core constants and types: register indexing, the outstanding-load
// counter width and a one-hot decode helper.
package core_pkg;

    localparam int NUM_REGS = 32;
    localparam int REG_W    = 5;
    localparam int CNT_W    = 4;

    typedef logic [REG_W-1:0] reg_idx_t;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam reg_idx_t REG_ZERO = 5'd0;

    function automatic logic [NUM_REGS-1:0] idx_onehot(input reg_idx_t idx);
        return {{(NUM_REGS-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/load_scoreboard_if.sv
// Decode/writeback bundle between the issue stage and the load scoreboard.
// master = pipeline side, slave = scoreboard.
interface load_scoreboard_if;
    import core_pkg::*;

    logic     id_valid;
    reg_idx_t id_rs1;
    reg_idx_t id_rs2;
    logic     id_use_rs1;
    logic     id_use_rs2;
    reg_idx_t id_rd;
    logic     id_reg_write;
    logic     id_is_load;
    logic     wb_valid;
    reg_idx_t wb_rd;
    logic     stall;
    cnt_t     outst_cnt;
    logic     full;
    logic     err;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
               id_reg_write, id_is_load, wb_valid, wb_rd,
        input  stall, outst_cnt, full, err
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
               id_reg_write, id_is_load, wb_valid, wb_rd,
        output stall, outst_cnt, full, err
    );

endinterface

// File: rtl/outst_counter.sv
// Saturating up/down counter of in-flight memory operations with a registered
// full flag and an underflow indication; shared by the load scoreboard and store buffer.
module outst_counter
    import core_pkg::*;
#(
    parameter int MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc_i,
    input  logic dec_i,
    output cnt_t cnt_o,
    output logic full_o,
    output logic underflow_o
);

    localparam cnt_t MAX_C = cnt_t'(MAX);

    cnt_t cnt_q;
    cnt_t cnt_d;
    logic full_q;
    logic full_d;

    // Next count: a decrement at zero is dropped, an increment at MAX is dropped.
    always_comb begin
        cnt_d = cnt_q;
        case ({inc_i, dec_i})
            2'b10: begin
                if (cnt_q != MAX_C) cnt_d = cnt_q + 4'd1;
                else                cnt_d = cnt_q;
            end
            2'b01: begin
                if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
                else               cnt_d = cnt_q;
            end
            2'b11: begin
                if (cnt_q == 4'd0) cnt_d = 4'd1;
                else               cnt_d = cnt_q;
            end
            default: cnt_d = cnt_q;
        endcase
        full_d = (cnt_d == MAX_C);
    end

    // Count and full flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= 4'd0;
            full_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            full_q <= full_d;
        end
    end

    assign cnt_o       = cnt_q;
    assign full_o      = full_q;
    assign underflow_o = dec_i && (cnt_q == 4'd0);

endmodule

// File: rtl/load_scoreboard.sv
// Load scoreboard: stalls decode on RAW/WAW against in-flight loads and on load capacity.
// Optional LOAD_SCOREBOARD_WB_BYPASS_EN lets decode proceed in the writeback cycle.
module load_scoreboard
    import core_pkg::*;
#(
    parameter int MAX_OUTST = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    load_scoreboard_if.slave   sb
);

    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pending_d;
    logic [NUM_REGS-1:0] pending_eff_s;
    logic [NUM_REGS-1:0] wb_mask_s;
    logic [NUM_REGS-1:0] set_mask_s;
    logic                err_q;
    logic                err_d;
    logic                raw1_s;
    logic                raw2_s;
    logic                waw_s;
    logic                cap_s;
    logic                stall_s;
    logic                load_issue_s;
    logic                underflow_s;
    logic                full_s;
    cnt_t                cnt_s;

    // Register being released by the returning load this cycle.
    always_comb begin
        if (sb.wb_valid) wb_mask_s = idx_onehot(sb.wb_rd);
        else             wb_mask_s = '0;
    end

`ifdef LOAD_SCOREBOARD_WB_BYPASS_EN
    // MEM/WB forwarding supplies the returning data, so that register is not a hazard.
    assign pending_eff_s = pending_q & ~wb_mask_s;
`else
    assign pending_eff_s = pending_q;
`endif

    // Hazard detection against the decode-stage instruction.
    always_comb begin
        raw1_s       = sb.id_use_rs1   && (sb.id_rs1 != REG_ZERO) && pending_eff_s[sb.id_rs1];
        raw2_s       = sb.id_use_rs2   && (sb.id_rs2 != REG_ZERO) && pending_eff_s[sb.id_rs2];
        waw_s        = sb.id_reg_write && (sb.id_rd  != REG_ZERO) && pending_eff_s[sb.id_rd];
        cap_s        = sb.id_is_load   && full_s;
        stall_s      = sb.id_valid && (raw1_s || raw2_s || waw_s || cap_s);
        load_issue_s = sb.id_valid && !stall_s && sb.id_is_load;
    end

    // Next pending vector and sticky error; a new load's set wins over a same-index clear.
    always_comb begin
        if (load_issue_s && (sb.id_rd != REG_ZERO)) set_mask_s = idx_onehot(sb.id_rd);
        else                                        set_mask_s = '0;
        pending_d = (pending_q & ~wb_mask_s) | set_mask_s;
        err_d     = err_q || underflow_s ||
                    (sb.wb_valid && (sb.wb_rd != REG_ZERO) && !pending_q[sb.wb_rd]);
    end

    // Pending vector and error flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            err_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            err_q     <= err_d;
        end
    end

    outst_counter #(
        .MAX (MAX_OUTST)
    ) u_cnt (
        .clk         (clk),
        .rst_n       (rst_n),
        .inc_i       (load_issue_s),
        .dec_i       (sb.wb_valid),
        .cnt_o       (cnt_s),
        .full_o      (full_s),
        .underflow_o (underflow_s)
    );

    assign sb.stall     = stall_s;
    assign sb.outst_cnt = cnt_s;
    assign sb.full      = full_s;
    assign sb.err       = err_q;

endmodule

// File: tb/tb_load_scoreboard.sv
// Self-checking bench for load_scoreboard: directed scenarios plus randomized
// traffic against a set/queue reference model of in-flight loads.
module tb_load_scoreboard;
    import core_pkg::*;

    localparam int MAX_OUTST = 4;
`ifdef LOAD_SCOREBOARD_WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    load_scoreboard_if bus();

    load_scoreboard #(.MAX_OUTST(MAX_OUTST)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sb    (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: which registers await load data, how many loads are out, error seen.
    bit mdl_pend[NUM_REGS];
    int mdl_cnt;
    bit mdl_err;
    int inflight[$];

    function automatic bit busy(input int r);
        if (r == 0) return 1'b0;
        if (BYPASS && bus.wb_valid && int'(bus.wb_rd) == r) return 1'b0;
        return mdl_pend[r];
    endfunction

    function automatic bit model_stall();
        bit hz;
        hz = (bus.id_use_rs1 && busy(int'(bus.id_rs1))) ||
             (bus.id_use_rs2 && busy(int'(bus.id_rs2))) ||
             (bus.id_reg_write && busy(int'(bus.id_rd))) ||
             (bus.id_is_load && mdl_cnt == MAX_OUTST);
        return bus.id_valid && hz;
    endfunction

    task automatic model_reset();
        foreach (mdl_pend[i]) mdl_pend[i] = 1'b0;
        mdl_cnt = 0;
        mdl_err = 1'b0;
        inflight.delete();
    endtask

    task automatic model_clock();
        bit issue_ld;
        issue_ld = bus.id_valid && bus.id_is_load && !model_stall();
        if (bus.wb_valid) begin
            if (mdl_cnt == 0) mdl_err = 1'b1;
            else              mdl_cnt--;
            if (bus.wb_rd != 0 && !mdl_pend[bus.wb_rd]) mdl_err = 1'b1;
            mdl_pend[bus.wb_rd] = 1'b0;
        end
        if (issue_ld) begin
            mdl_cnt++;
            if (bus.id_rd != 0) mdl_pend[bus.id_rd] = 1'b1;
            inflight.push_back(int'(bus.id_rd));
        end
    endtask

    task automatic tick();
        model_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                         input int rd, input bit rw, input bit ld, input bit wbv, input int wbrd);
        bus.id_valid     = v;
        bus.id_rs1       = reg_idx_t'(rs1);
        bus.id_use_rs1   = u1;
        bus.id_rs2       = reg_idx_t'(rs2);
        bus.id_use_rs2   = u2;
        bus.id_rd        = reg_idx_t'(rd);
        bus.id_reg_write = rw;
        bus.id_is_load   = ld;
        bus.wb_valid     = wbv;
        bus.wb_rd        = reg_idx_t'(wbrd);
        #1;
    endtask

    task automatic idle();                drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);  endtask
    task automatic load(input int rd);    drive(1, 0, 0, 0, 0, rd, 1, 1, 0, 0); endtask
    task automatic alu(input int rs1, input int rs2, input int rd);
        drive(1, rs1, 1, rs2, 1, rd, 1, 0, 0, 0);
    endtask
    task automatic wb_only(input int rd); drive(0, 0, 0, 0, 0, 0, 0, 0, 1, rd);  endtask

    task automatic apply_reset();
        idle();
        rst_n = 1'b0;
        model_reset();
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        idle();
        #10;
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0b want 0", bus.stall); end
        checks++; if (bus.outst_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", bus.outst_cnt); end
        checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full: got %0b want 0", bus.full); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b want 0", bus.err); end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_load_use();
        bit exp_wb_stall;
        load(5);
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL lu_load_issue: got %0b want 0", bus.stall); end
        tick();
        for (int i = 0; i < 2; i++) begin
            alu(5, 1, 7);
            checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL lu_raw_stall: cycle %0d got %0b want 1", i, bus.stall); end
            tick();
        end
        exp_wb_stall = !BYPASS;
        drive(1, 5, 1, 1, 1, 7, 1, 0, 1, 5);
        checks++; if (bus.stall !== exp_wb_stall) begin errors++; $display("FAIL lu_wb_cycle: got %0b want %0b", bus.stall, exp_wb_stall); end
        tick();
        if (!BYPASS) begin
            alu(5, 1, 7);
            checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL lu_after_wb: got %0b want 0", bus.stall); end
            tick();
        end
        idle();
        checks++; if (bus.outst_cnt !== 4'd0) begin errors++; $display("FAIL lu_cnt: got %0d want 0", bus.outst_cnt); end
    endtask

    task automatic test_waw_x0();
        load(5);
        tick();
        drive(1, 0, 1, 0, 0, 5, 1, 0, 0, 0);
        checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL waw_stall: got %0b want 1", bus.stall); end
        tick();
        wb_only(5);
        tick();
        load(0);
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL x0_load: got %0b want 0", bus.stall); end
        tick();
        alu(0, 0, 3);
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL x0_read: got %0b want 0", bus.stall); end
        checks++; if (bus.outst_cnt !== 4'd1) begin errors++; $display("FAIL x0_cnt: got %0d want 1", bus.outst_cnt); end
        tick();
        wb_only(0);
        tick();
        idle();
        checks++; if (bus.outst_cnt !== 4'd0) begin errors++; $display("FAIL x0_drain: got %0d want 0", bus.outst_cnt); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL x0_err: got %0b want 0", bus.err); end
    endtask

    task automatic test_capacity();
        for (int r = 1; r <= 4; r++) begin
            load(r);
            checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL cap_fill: x%0d got %0b want 0", r, bus.stall); end
            tick();
        end
        load(20);
        checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL cap_full: got %0b want 1", bus.full); end
        checks++; if (bus.outst_cnt !== 4'd4) begin errors++; $display("FAIL cap_cnt: got %0d want 4", bus.outst_cnt); end
        checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL cap_fifth: got %0b want 1", bus.stall); end
        tick();
        alu(10, 11, 9);
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL cap_alu: got %0b want 0", bus.stall); end
        tick();
        wb_only(1);
        tick();
        load(20);
        checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL cap_unfull: got %0b want 0", bus.full); end
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL cap_fifth_go: got %0b want 0", bus.stall); end
        tick();
        for (int r = 2; r <= 4; r++) begin
            wb_only(r);
            tick();
        end
        wb_only(20);
        tick();
        idle();
        checks++; if (bus.outst_cnt !== 4'd0) begin errors++; $display("FAIL cap_drain: got %0d want 0", bus.outst_cnt); end
    endtask

    task automatic test_simultaneous();
        load(1);
        tick();
        load(2);
        tick();
        drive(1, 0, 0, 0, 0, 8, 1, 1, 1, 1);
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL sim_issue: got %0b want 0", bus.stall); end
        tick();
        alu(8, 0, 9);
        checks++; if (bus.outst_cnt !== 4'd2) begin errors++; $display("FAIL sim_cnt: got %0d want 2", bus.outst_cnt); end
        checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL sim_pend8: got %0b want 1", bus.stall); end
        alu(1, 0, 9);
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL sim_pend1: got %0b want 0", bus.stall); end
        tick();
        wb_only(2);
        tick();
        wb_only(8);
        tick();
        idle();
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL sim_err: got %0b want 0", bus.err); end
    endtask

    task automatic test_protocol_err();
        load(13);
        tick();
        wb_only(12);
        tick();
        idle();
        checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL perr_unset: got %0b want 1", bus.err); end
        checks++; if (bus.outst_cnt !== 4'd0) begin errors++; $display("FAIL perr_unset_cnt: got %0d want 0", bus.outst_cnt); end
        apply_reset();
        wb_only(0);
        tick();
        idle();
        checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL perr_under: got %0b want 1", bus.err); end
        checks++; if (bus.outst_cnt !== 4'd0) begin errors++; $display("FAIL perr_under_cnt: got %0d want 0", bus.outst_cnt); end
        tick();
        checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL perr_sticky: got %0b want 1", bus.err); end
    endtask

    task automatic test_reset_midflight();
        load(5);
        tick();
        load(6);
        tick();
        idle();
        checks++; if (bus.outst_cnt !== 4'd2) begin errors++; $display("FAIL mid_pre_cnt: got %0d want 2", bus.outst_cnt); end
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if (bus.outst_cnt !== 4'd0) begin errors++; $display("FAIL mid_cnt: got %0d want 0", bus.outst_cnt); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL mid_err: got %0b want 0", bus.err); end
        alu(5, 6, 7);
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL mid_stall_rst: got %0b want 0", bus.stall); end
        rst_n = 1'b1;
        idle();
        @(posedge clk);
        #1;
        alu(5, 6, 7);
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL mid_stall_after: got %0b want 0", bus.stall); end
        tick();
    endtask

    task automatic test_random();
        bit wbv;
        int wbrd;
        bit ld;
        for (int cyc = 0; cyc < 400; cyc++) begin
            wbv  = 1'b0;
            wbrd = 0;
            if (inflight.size() > 0 && $urandom_range(2, 0) == 0) begin
                int k;
                k    = $urandom_range(inflight.size() - 1, 0);
                wbv  = 1'b1;
                wbrd = inflight[k];
                inflight.delete(k);
            end
            ld = ($urandom_range(2, 0) == 0);
            drive($urandom_range(3, 0) != 0,
                  $urandom_range(7, 0), $urandom_range(1, 0),
                  $urandom_range(7, 0), $urandom_range(1, 0),
                  $urandom_range(7, 0), ld ? 1'b1 : 1'($urandom_range(1, 0)), ld,
                  wbv, wbrd);
            checks++; if (bus.stall !== model_stall()) begin errors++; $display("FAIL rnd_stall: cyc %0d got %0b want %0b", cyc, bus.stall, model_stall()); end
            checks++; if (int'(bus.outst_cnt) != mdl_cnt) begin errors++; $display("FAIL rnd_cnt: cyc %0d got %0d want %0d", cyc, bus.outst_cnt, mdl_cnt); end
            checks++; if (bus.full !== (mdl_cnt == MAX_OUTST)) begin errors++; $display("FAIL rnd_full: cyc %0d got %0b want %0b", cyc, bus.full, mdl_cnt == MAX_OUTST); end
            checks++; if (bus.err !== mdl_err) begin errors++; $display("FAIL rnd_err: cyc %0d got %0b want %0b", cyc, bus.err, mdl_err); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_waw_x0();
        test_capacity();
        test_simultaneous();
        test_protocol_err();
        test_reset_midflight();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
